// File: rtl/register_write_arbiter.sv
// Round-robin owner of the register bank's single write port. Bursts lock the port
// for at most MAX_BURST beats; the accepted beat is range-checked and registered.
module register_write_arbiter #(
   parameter int NUM_REGS  = 16,
   parameter int WIDTH     = 8,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 4,
   localparam int AW = $clog2(NUM_REGS),
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_last,
   input  logic [NUM_REQ*AW-1:0]    req_addr,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     wr_en,
   output logic [AW-1:0]            wr_addr,
   output logic [WIDTH-1:0]         wr_data,
   output logic                     addr_err,
   output logic                     busy,
   output logic [IW-1:0]            lock_id
);

   localparam logic [0:0]    ST_IDLE   = 1'b0;
   localparam logic [0:0]    ST_LOCK   = 1'b1;
   localparam int            BW        = $clog2(MAX_BURST + 1);
   localparam logic [AW:0]   LIMIT     = (AW+1)'(NUM_REGS);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

   logic [0:0]          r_state;
   logic [IW-1:0]       r_rr_ptr;
   logic [IW-1:0]       r_owner;
   logic [BW-1:0]       r_beat_cnt;
   logic                r_wr_en;
   logic [AW-1:0]       r_wr_addr;
   logic [WIDTH-1:0]    r_wr_data;
   logic                r_addr_err;
   logic                r_busy;
   logic [IW-1:0]       r_lock_id;

   logic                w_any;
   logic [IW-1:0]       w_winner;
   logic [IW-1:0]       w_scan;
   logic [IW-1:0]       w_sel;
   logic [NUM_REQ-1:0]  w_ready;
   logic                w_accept;
   logic [AW-1:0]       w_addr;
   logic [WIDTH-1:0]    w_data;
   logic                w_last;
   logic                w_in_range;
   logic [BW-1:0]       w_beats;
   logic                w_release;

   // Wrapping increment; NUM_REQ need not be a power of two.
   function automatic logic [IW-1:0] f_next(input logic [IW-1:0] idx);
      logic [IW-1:0] nxt;
      if (idx == LAST_IDX) begin
         nxt = IW'(0);
      end else begin
         nxt = idx + IW'(1);
      end
      return nxt;
   endfunction

   // Round-robin scan starting at the pointer; first valid requester wins.
   always_comb begin
      w_any    = 1'b0;
      w_winner = IW'(0);
      w_scan   = r_rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_any && req_valid[w_scan]) begin
            w_any    = 1'b1;
            w_winner = w_scan;
         end else begin
            w_any    = w_any;
         end
         w_scan = f_next(w_scan);
      end
   end

   // Grant, selected beat and burst bookkeeping; a held reset withdraws every grant.
   always_comb begin
      w_ready = {NUM_REQ{1'b0}};
      if (r_state == ST_LOCK) begin
         w_sel = r_owner;
      end else begin
         w_sel = w_winner;
      end
      if (rst) begin
         w_ready = {NUM_REQ{1'b0}};
      end else if (r_state == ST_LOCK) begin
         w_ready[r_owner] = 1'b1;
      end else if (w_any) begin
         w_ready[w_winner] = 1'b1;
      end else begin
         w_ready = {NUM_REQ{1'b0}};
      end
      w_accept   = |(req_valid & w_ready);
      w_addr     = req_addr[w_sel*AW +: AW];
      w_data     = req_data[w_sel*WIDTH +: WIDTH];
      w_last     = req_last[w_sel];
      w_in_range = ({1'b0, w_addr} < LIMIT);
      if (r_state == ST_LOCK) begin
         w_beats = r_beat_cnt + BW'(1);
      end else begin
         w_beats = BW'(1);
      end
      // MAX_BURST of 1 makes every first beat a release, so no lock is ever taken.
      w_release = w_last || (w_beats == BURST_MAX);
   end

   // Arbitration state: pointer, lock owner, beat count and the busy/lock_id view of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_rr_ptr   <= IW'(0);
         r_owner    <= IW'(0);
         r_beat_cnt <= BW'(0);
         r_busy     <= 1'b0;
         r_lock_id  <= IW'(0);
      end else if (w_accept) begin
         if (w_release) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= f_next(w_sel);
            r_beat_cnt <= BW'(0);
            r_busy     <= 1'b0;
            r_lock_id  <= IW'(0);
         end else begin
            r_state    <= ST_LOCK;
            r_owner    <= w_sel;
            r_beat_cnt <= w_beats;
            r_busy     <= 1'b1;
            r_lock_id  <= w_sel;
         end
      end
   end

   // Registered write port; address and data hold between valid writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_en    <= 1'b0;
         r_addr_err <= 1'b0;
         r_wr_addr  <= AW'(0);
         r_wr_data  <= WIDTH'(0);
      end else begin
         r_wr_en    <= w_accept && w_in_range;
         r_addr_err <= w_accept && !w_in_range;
         if (w_accept && w_in_range) begin
            r_wr_addr <= w_addr;
            r_wr_data <= w_data;
         end
      end
   end

   assign req_ready = w_ready;
   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign addr_err  = r_addr_err;
   assign busy      = r_busy;
   assign lock_id   = r_lock_id;

   register_write_arbiter_chk #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .req_ready (req_ready),
      .wr_en     (wr_en),
      .addr_err  (addr_err),
      .busy      (busy),
      .lock_id   (lock_id)
   );

endmodule

// Structural invariants of the arbiter outputs.
module register_write_arbiter_chk #(
   parameter int NUM_REQ = 4,
   parameter int IW      = 2
) (
   input logic               clk,
   input logic               rst,
   input logic [NUM_REQ-1:0] req_ready,
   input logic               wr_en,
   input logic               addr_err,
   input logic               busy,
   input logic [IW-1:0]      lock_id
);

   a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
   a_wr_xor_err:    assert property (@(posedge clk) disable iff (rst) !(wr_en && addr_err));
   a_idle_lock_id:  assert property (@(posedge clk) disable iff (rst) (!busy) |-> (lock_id == IW'(0)));

endmodule
